xpb_accum_sequencer: RTL and testbench
======================================

// Module: xpb_accum_sequencer
// PURPOSE
//  Sequences one shared XPB lookup-table bank across NUM_DIGITS 5-bit digits of a reduction word.
//  Per digit: issues a table read, accumulates the returned WORD_W-bit entry into a wide sum.
//  Returns the full non-reduced sum to the modular-square reduction stage via a valid/ready handshake.
//  One table bank replaces NUM_DIGITS parallel banks.
// PARAMETERS
//  DIGIT_W    5     digit width; equals table select width
//  NUM_DIGITS 8     digits per job; power of two, >=2
//  WORD_W     1024  table entry width
//  TABLE_LAT  1     table read latency in cycles, >=1; tbl_data valid TABLE_LAT cycles after tbl_rd_en
//  SUM_W      WORD_W+$clog2(NUM_DIGITS)  accumulator / sum_out width (local)
// PORTS
//  clk          in   1                    clock; all logic on rising edge
//  reset        in   1                    synchronous, active-high
//  start_valid  in   1                    job request
//  start_ready  out  1                    high only in IDLE
//  digits_in    in   NUM_DIGITS*DIGIT_W   digit i = digits_in[i*DIGIT_W +: DIGIT_W]
//  tbl_rd_en    out  1                    table read strobe
//  tbl_sel      out  $clog2(NUM_DIGITS)   table bank/digit index being read
//  tbl_digit    out  DIGIT_W              table data_in for this read
//  tbl_data     in   WORD_W               table entry, TABLE_LAT cycles after the read
//  sum_valid    out  1                    result available
//  sum_ready    in   1                    consumer accepts result
//  sum_out      out  SUM_W                sum of all NUM_DIGITS entries
//  busy         out  1                    state != IDLE
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, acc=0, sum_out=0, sum_valid=0, tbl_rd_en=0, tbl_sel=0,
//   tbl_digit=0, busy=0, read-pending pipe cleared. start_ready=1 the cycle after reset deasserts.
//  FSM: IDLE -> ISSUE when start_valid&&start_ready. Latch digits_in; clear acc and idx.
//   ISSUE: one read per cycle. tbl_sel=idx, tbl_digit=digit[idx], tbl_rd_en=1; idx++.
//    Go to DRAIN after idx==NUM_DIGITS-1 is issued.
//   DRAIN: TABLE_LAT cycles; no reads issued.
//    Go to DONE after the last pending read has been accumulated.
//   DONE: sum_valid=1, sum_out=acc, both held stable until sum_ready; then go to IDLE.
//  Read tracking: TABLE_LAT-deep pending shift pipe carries rd_en.
//   acc += zero-extend(tbl_data) at the end of any cycle whose pipe output is 1.
//  Latency: handshake in cycle T -> reads in T+1..T+NUM_DIGITS ->
//   sum_valid first high in cycle T+NUM_DIGITS+TABLE_LAT+1.
//  Width: SUM_W bits cannot overflow; the sum is not reduced modulo anything.
//  start_ready=0 in ISSUE/DRAIN/DONE; start_valid ignored there; no same-cycle restart from DONE.
//  digits_in changes after acceptance have no effect on the running job.
//  Reset mid-job: the next cycle is IDLE with all outputs at reset values.
//   Pending table data is discarded and never reaches acc.
//  tbl_sel/tbl_digit are don't-care when tbl_rd_en=0; drive them to 0.
// CONFIGURATION
//  XPB_SEQ_SKIP_ZERO_EN defined: in ISSUE, a digit==0 slot drives tbl_rd_en=0 (power saving).
//   The slot is not accumulated; idx still advances.
//   Timing and latency are unchanged; sum is identical because a zero digit's entry is 0.
//  Undefined: every slot issues tbl_rd_en=1 regardless of digit value.
// TESTING  (table model: entry = digit==0 ? 0 : 32*sel+digit, registered, TABLE_LAT=1, N=8)
//  1 Reset held 3 cycles then released -> all outputs 0, start_ready=1, busy=0.
//  2 All digits 5'h1F, start in T -> tbl_sel 0..7 in T+1..T+8; sum_valid at T+10; sum_out=0x478.
//  3 Model returns all-ones for every read -> sum_out = 2^1027-8 (bits[1026:3] set, [2:0]=0).
//  4 sum_ready low 5 cycles in DONE, start_valid=1 throughout ->
//    sum_out/sum_valid stable, start_ready=0, no reads issued.
//  5 reset pulse on the 3rd ISSUE cycle -> IDLE next cycle, tbl_rd_en=0;
//    a following all-1F job still gives 0x478.
//  6 Digits 2,5 = 0, others 1F -> sum_out=0x35A both builds;
//    with XPB_SEQ_SKIP_ZERO_EN, tbl_rd_en low in slots 2,5; without it, high in all 8.

Source files
------------

// File: rtl/xpb_accum_sequencer_if.sv
// Bundles the job-start handshake, the shared XPB table read bus and the
// sum-return handshake of xpb_accum_sequencer.
interface xpb_accum_sequencer_if #(
    parameter int DIGIT_W    = 5,
    parameter int NUM_DIGITS = 8,
    parameter int WORD_W     = 1024
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int SUM_W = WORD_W + SEL_W;

    logic                          start_valid;
    logic                          start_ready;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic                          tbl_rd_en;
    logic [SEL_W-1:0]              tbl_sel;
    logic [DIGIT_W-1:0]            tbl_digit;
    logic [WORD_W-1:0]             tbl_data;
    logic                          sum_valid;
    logic                          sum_ready;
    logic [SUM_W-1:0]              sum_out;
    logic                          busy;

    // master: job requester plus table bank plus sum consumer
    modport master (
        output start_valid, digits_in, tbl_data, sum_ready,
        input  start_ready, tbl_rd_en, tbl_sel, tbl_digit, sum_valid, sum_out, busy
    );

    // slave: the sequencer itself
    modport slave (
        input  start_valid, digits_in, tbl_data, sum_ready,
        output start_ready, tbl_rd_en, tbl_sel, tbl_digit, sum_valid, sum_out, busy
    );
endinterface

// File: rtl/xpb_accum_sequencer.sv
// Time-multiplexes one XPB table bank over NUM_DIGITS digits and returns the unreduced sum.
// Optional macro XPB_SEQ_SKIP_ZERO_EN suppresses table reads for zero digits.
module xpb_accum_sequencer #(
    parameter int DIGIT_W    = 5,
    parameter int NUM_DIGITS = 8,
    parameter int WORD_W     = 1024,
    parameter int TABLE_LAT  = 1
) (
    input logic                  clk,
    input logic                  reset,
    xpb_accum_sequencer_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int SUM_W = WORD_W + SEL_W;
    localparam int CNT_W = (TABLE_LAT > 1) ? $clog2(TABLE_LAT) : 1;
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(TABLE_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                        state;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
    logic [SEL_W-1:0]              idx;
    logic [CNT_W-1:0]              drain_cnt;
    logic [TABLE_LAT-1:0]          pend;
    logic [SUM_W-1:0]              acc;
    logic [SUM_W-1:0]              acc_nxt;
    logic                          rd_en_q;
    logic [SEL_W-1:0]              sel_q;
    logic [DIGIT_W-1:0]            digit_q;
    logic                          sum_valid_q;
    logic [SUM_W-1:0]              sum_q;
    logic [SEL_W-1:0]              next_idx;
    logic [DIGIT_W-1:0]            next_digit;
    logic [DIGIT_W-1:0]            first_digit;
    logic                          next_en;
    logic                          first_en;

    always_comb begin
        next_idx    = idx + 1'b1;
        next_digit  = digits_q[next_idx*DIGIT_W +: DIGIT_W];
        first_digit = bus.digits_in[DIGIT_W-1:0];
`ifdef XPB_SEQ_SKIP_ZERO_EN
        next_en  = (next_digit != '0);
        first_en = (first_digit != '0);
`else
        next_en  = 1'b1;
        first_en = 1'b1;
`endif
        // Only reads that actually went out come back through the pending pipe
        acc_nxt = pend[TABLE_LAT-1] ? acc + SUM_W'(bus.tbl_data) : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            digits_q    <= '0;
            idx         <= '0;
            drain_cnt   <= '0;
            pend        <= '0;
            acc         <= '0;
            rd_en_q     <= 1'b0;
            sel_q       <= '0;
            digit_q     <= '0;
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            pend <= (pend << 1) | TABLE_LAT'(rd_en_q);
            acc  <= acc_nxt;
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        state    <= ISSUE;
                        digits_q <= bus.digits_in;
                        idx      <= '0;
                        acc      <= '0;
                        rd_en_q  <= first_en;
                        sel_q    <= '0;
                        digit_q  <= first_en ? first_digit : '0;
                    end
                end
                // The slot presented this cycle is idx; the edge presents idx+1
                ISSUE: begin
                    if (idx == LAST_IDX) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        rd_en_q   <= 1'b0;
                        sel_q     <= '0;
                        digit_q   <= '0;
                    end else begin
                        idx     <= next_idx;
                        rd_en_q <= next_en;
                        sel_q   <= next_en ? next_idx : '0;
                        digit_q <= next_en ? next_digit : '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state       <= DONE;
                        sum_q       <= acc_nxt;
                        sum_valid_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.sum_ready) begin
                        state       <= IDLE;
                        sum_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.tbl_rd_en   = rd_en_q;
    assign bus.tbl_sel     = sel_q;
    assign bus.tbl_digit   = digit_q;
    assign bus.sum_valid   = sum_valid_q;
    assign bus.sum_out     = sum_q;
endmodule

// File: tb/tb_xpb_accum_sequencer.sv
// Scoreboard bench for xpb_accum_sequencer: a registered table model answers reads,
// expected sums are queued at job start and compared when the sum handshake completes.
module tb_xpb_accum_sequencer;
    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 8;
    localparam int WORD_W     = 1024;
    localparam int TABLE_LAT  = 1;
    localparam int SEL_W      = $clog2(NUM_DIGITS);
    localparam int SUM_W      = WORD_W + SEL_W;
    localparam int DBUS_W     = NUM_DIGITS * DIGIT_W;
    localparam logic [WORD_W-1:0] GARBAGE = {32{32'h0BAD_F00D}};
    localparam logic [DBUS_W-1:0] ALL_1F  = {NUM_DIGITS{5'h1F}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic all_ones_mode = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [SUM_W-1:0] exp_q[$];

    xpb_accum_sequencer_if #(.DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .WORD_W(WORD_W)) bus ();

    xpb_accum_sequencer #(
        .DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .WORD_W(WORD_W), .TABLE_LAT(TABLE_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] table_entry(input logic [SEL_W-1:0] sel,
                                                      input logic [DIGIT_W-1:0] d);
        return (d == '0) ? '0 : WORD_W'(32 * int'(sel) + int'(d));
    endfunction

    function automatic logic read_en(input logic [DIGIT_W-1:0] d);
`ifdef XPB_SEQ_SKIP_ZERO_EN
        return d != '0;
`else
        return d == d;
`endif
    endfunction

    function automatic logic [SUM_W-1:0] expected_sum(input logic [DBUS_W-1:0] digits,
                                                      input logic ones);
        logic [SUM_W-1:0] s;
        logic [DIGIT_W-1:0] d;
        s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = digits[i*DIGIT_W +: DIGIT_W];
            if (read_en(d))
                s = s + (ones ? SUM_W'({WORD_W{1'b1}}) : SUM_W'(table_entry(SEL_W'(i), d)));
        end
        return s;
    endfunction

    // Registered table bank; returns junk when not read so stray accumulation shows up
    always @(posedge clk) begin
        if (bus.tbl_rd_en)
            bus.tbl_data <= all_ones_mode ? {WORD_W{1'b1}} : table_entry(bus.tbl_sel, bus.tbl_digit);
        else
            bus.tbl_data <= GARBAGE;
    end

    task automatic checkOutput(input string tag, input logic [SUM_W-1:0] act,
                               input logic [SUM_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got hi=%0h lo=%0h, expected hi=%0h lo=%0h", tag,
                     act[SUM_W-1 -: 32], act[95:0], exp[SUM_W-1 -: 32], exp[95:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DBUS_W-1:0] digits, input logic ones,
                                 input int hold, input logic hold_sv);
        logic [SUM_W-1:0]   held;
        logic [DIGIT_W-1:0] d;
        logic               en;
        int                 n;
        all_ones_mode = ones;
        exp_q.push_back(expected_sum(digits, ones));
        checkOutput("start_ready_idle", SUM_W'(bus.start_ready), SUM_W'(1));
        bus.digits_in   = digits;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = hold_sv;
        bus.digits_in   = DBUS_W'({$urandom(), $urandom()});
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d  = digits[i*DIGIT_W +: DIGIT_W];
            en = read_en(d);
            checkOutput($sformatf("rd_en_slot%0d", i), SUM_W'(bus.tbl_rd_en), SUM_W'(en));
            checkOutput($sformatf("sel_slot%0d", i), SUM_W'(bus.tbl_sel), en ? SUM_W'(i) : '0);
            checkOutput($sformatf("digit_slot%0d", i), SUM_W'(bus.tbl_digit), en ? SUM_W'(d) : '0);
            checkOutput("busy_issue", SUM_W'(bus.busy), SUM_W'(1));
            checkOutput("start_ready_issue", SUM_W'(bus.start_ready), '0);
            step();
        end
        checkOutput("rd_en_drain", SUM_W'(bus.tbl_rd_en), '0);
        checkOutput("valid_drain", SUM_W'(bus.sum_valid), '0);
        n = 0;
        while (!bus.sum_valid && n < 16) begin
            step();
            n++;
        end
        checkOutput("valid_latency", SUM_W'(n), SUM_W'(TABLE_LAT));
        if (bus.sum_valid) begin
            held = bus.sum_out;
            for (int k = 0; k < hold; k++) begin
                checkOutput("start_ready_done", SUM_W'(bus.start_ready), '0);
                checkOutput("rd_en_done", SUM_W'(bus.tbl_rd_en), '0);
                step();
                checkOutput("sum_hold", bus.sum_out, held);
                checkOutput("valid_hold", SUM_W'(bus.sum_valid), SUM_W'(1));
            end
            bus.start_valid = 1'b0;
            bus.sum_ready   = 1'b1;
            checkOutput("sum_out", bus.sum_out, exp_q.pop_front());
            step();
            bus.sum_ready = 1'b0;
            checkOutput("valid_cleared", SUM_W'(bus.sum_valid), '0);
            checkOutput("start_ready_back", SUM_W'(bus.start_ready), SUM_W'(1));
            checkOutput("busy_back", SUM_W'(bus.busy), '0);
        end else begin
            bus.start_valid = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DBUS_W-1:0] digits;
        bus.start_valid = 1'b0;
        bus.digits_in   = '0;
        bus.sum_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        checkOutput("rst_start_ready", SUM_W'(bus.start_ready), SUM_W'(1));
        checkOutput("rst_busy", SUM_W'(bus.busy), '0);
        checkOutput("rst_rd_en", SUM_W'(bus.tbl_rd_en), '0);
        checkOutput("rst_sel", SUM_W'(bus.tbl_sel), '0);
        checkOutput("rst_digit", SUM_W'(bus.tbl_digit), '0);
        checkOutput("rst_valid", SUM_W'(bus.sum_valid), '0);
        checkOutput("rst_sum", bus.sum_out, '0);

        applyStimulus(ALL_1F, 1'b0, 0, 1'b0);
        applyStimulus(ALL_1F, 1'b1, 0, 1'b0);
        applyStimulus(ALL_1F, 1'b0, 5, 1'b1);

        // Abort a job on its third issue cycle
        bus.digits_in   = ALL_1F;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        step();
        step();
        checkOutput("sel_before_reset", SUM_W'(bus.tbl_sel), SUM_W'(2));
        reset = 1'b1;
        step();
        checkOutput("abort_rd_en", SUM_W'(bus.tbl_rd_en), '0);
        checkOutput("abort_busy", SUM_W'(bus.busy), '0);
        checkOutput("abort_start_ready", SUM_W'(bus.start_ready), SUM_W'(1));
        checkOutput("abort_valid", SUM_W'(bus.sum_valid), '0);
        checkOutput("abort_sel", SUM_W'(bus.tbl_sel), '0);
        reset = 1'b0;
        step();
        applyStimulus(ALL_1F, 1'b0, 0, 1'b0);

        digits = ALL_1F;
        digits[2*DIGIT_W +: DIGIT_W] = '0;
        digits[5*DIGIT_W +: DIGIT_W] = '0;
        applyStimulus(digits, 1'b0, 1, 1'b0);

        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                digits[i*DIGIT_W +: DIGIT_W] =
                    ($urandom_range(0, 3) == 0) ? '0 : DIGIT_W'($urandom_range(1, 31));
            applyStimulus(digits, 1'b0, j, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
